// File: rtl/conv_interleaver.sv
// Convolutional (Forney) interleaver / deinterleaver: a round-robin commutator
// feeds BRANCHES shift registers of depth i*M (MODE=0) or (BRANCHES-1-i)*M (MODE=1).
module conv_interleaver #(
    parameter int WIDTH    = 8,
    parameter int BRANCHES = 4,
    parameter int M        = 2,
    parameter int MODE     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sync_clr,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(BRANCHES)-1:0]  branch_idx
);

    localparam int IDX_W = $clog2(BRANCHES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BRANCHES - 1);

    logic [IDX_W-1:0] branch_idx_q, branch_idx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic [WIDTH-1:0] oldest [BRANCHES];
    logic [WIDTH-1:0] sel_data;

    for (genvar g = 0; g < BRANCHES; g++) begin : g_branch
        localparam int DEP = (MODE == 0) ? g * M : (BRANCHES - 1 - g) * M;

        logic adv;
        assign adv = in_valid && !sync_clr && (branch_idx_q == IDX_W'(g));

        if (DEP == 0) begin : g_bypass
            // A zero-depth branch hands the incoming symbol straight through.
            assign oldest[g] = in_data;
        end else begin : g_fifo
            logic [WIDTH-1:0] sr_q [DEP];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < DEP; k++) sr_q[k] <= '0;
                end else if (sync_clr) begin
                    for (int k = 0; k < DEP; k++) sr_q[k] <= '0;
                end else if (adv) begin
                    for (int k = DEP - 1; k > 0; k--) sr_q[k] <= sr_q[k-1];
                    sr_q[0] <= in_data;
                end
            end

            assign oldest[g] = sr_q[DEP-1];
        end
    end

    always_comb begin
        sel_data = '0;
        for (int b = 0; b < BRANCHES; b++) begin
            if (branch_idx_q == IDX_W'(b)) sel_data = oldest[b];
        end
    end

    always_comb begin
        branch_idx_d = branch_idx_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        if (sync_clr) begin
            branch_idx_d = '0;
            out_data_d   = '0;
        end else if (in_valid) begin
            out_valid_d  = 1'b1;
            out_data_d   = sel_data;
            branch_idx_d = (branch_idx_q == LAST_IDX) ? '0 : branch_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_idx_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            branch_idx_q <= branch_idx_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign branch_idx = branch_idx_q;

endmodule

// File: tb/tb_conv_interleaver.sv
// Bench for conv_interleaver: 3-branch interleaver and deinterleaver driven in
// parallel, plus a 4-branch interleaver->deinterleaver round-trip chain.
module tb_conv_interleaver;

    logic       clk;
    logic       reset;
    logic       sync_clr;
    logic       in_valid;
    logic [7:0] in_data;

    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic [1:0] a_idx, b_idx;

    logic       c_clr, c_in_valid, c_mid_valid, c_out_valid;
    logic [7:0] c_in_data, c_mid_data, c_out_data;
    logic [1:0] c_idx0, c_idx1;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    conv_interleaver #(.WIDTH(8), .BRANCHES(3), .M(1), .MODE(0)) u_a (
        .clk(clk), .reset(reset), .sync_clr(sync_clr), .in_valid(in_valid),
        .in_data(in_data), .out_valid(a_valid), .out_data(a_data), .branch_idx(a_idx));

    conv_interleaver #(.WIDTH(8), .BRANCHES(3), .M(1), .MODE(1)) u_b (
        .clk(clk), .reset(reset), .sync_clr(sync_clr), .in_valid(in_valid),
        .in_data(in_data), .out_valid(b_valid), .out_data(b_data), .branch_idx(b_idx));

    conv_interleaver #(.WIDTH(8), .BRANCHES(4), .M(2), .MODE(0)) u_c0 (
        .clk(clk), .reset(reset), .sync_clr(c_clr), .in_valid(c_in_valid),
        .in_data(c_in_data), .out_valid(c_mid_valid), .out_data(c_mid_data), .branch_idx(c_idx0));

    conv_interleaver #(.WIDTH(8), .BRANCHES(4), .M(2), .MODE(1)) u_c1 (
        .clk(clk), .reset(reset), .sync_clr(c_clr), .in_valid(c_mid_valid),
        .in_data(c_mid_data), .out_valid(c_out_valid), .out_data(c_out_data), .branch_idx(c_idx1));

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        sync_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        sync_clr = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Reference model: each branch is a FIFO pre-loaded with its delay in zeros.
    logic [7:0] qa [3][$];
    logic [7:0] qb [3][$];
    int         m_idx;
    logic       m_valid;
    logic [7:0] m_da, m_db;

    task automatic model_clr();
        for (int b = 0; b < 3; b++) begin
            qa[b].delete();
            qb[b].delete();
            for (int k = 0; k < b; k++) qa[b].push_back(8'd0);
            for (int k = 0; k < 2 - b; k++) qb[b].push_back(8'd0);
        end
        m_idx   = 0;
        m_valid = 1'b0;
        m_da    = 8'd0;
        m_db    = 8'd0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c);
        if (c) begin
            model_clr();
        end else if (v) begin
            qa[m_idx].push_back(d);
            qb[m_idx].push_back(d);
            m_da    = qa[m_idx].pop_front();
            m_db    = qb[m_idx].pop_front();
            m_valid = 1'b1;
            m_idx   = (m_idx + 1) % 3;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [1:0] eidx;
    } vec_t;

    vec_t tbl[9];
    int   ea_l[9];
    int   eb_l[9];
    int   pat[6];
    int   got[$];

    initial begin
        int n;
        int last_a, last_b;
        logic v;
        logic c;
        logic [7:0] d;

        ea_l = '{1, 0, 0, 4, 2, 0, 7, 5, 3};
        eb_l = '{0, 0, 3, 0, 2, 6, 1, 5, 9};
        pat  = '{1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 9; i++) begin
            tbl[i].v    = 1'b1;
            tbl[i].d    = 8'(i + 1);
            tbl[i].ea   = 8'(ea_l[i]);
            tbl[i].eb   = 8'(eb_l[i]);
            tbl[i].eidx = 2'((i + 1) % 3);
        end

        reset = 1'b1; sync_clr = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        c_clr = 1'b0; c_in_valid = 1'b0; c_in_data = 8'd0;
        #2;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_a_idx", a_idx, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_c_idx", {c_idx0, c_idx1}, 0);
        chk("rst_c_valid", c_out_valid, 0);
        reset = 1'b0;

        // Continuous 1..9 through interleaver and deinterleaver.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].d, 1'b0);
            chk("tbl_a_valid", a_valid, 1);
            chk("tbl_a_data", a_data, tbl[i].ea);
            chk("tbl_b_data", b_data, tbl[i].eb);
            chk("tbl_idx", a_idx, tbl[i].eidx);
        end
        step(1'b0, 8'd0, 1'b0);
        chk("tbl_idle_valid", a_valid, 0);
        chk("tbl_idle_hold", a_data, 3);

        // Round trip through the 4-branch chain.
        for (int cyc = 0; cyc < 70; cyc++) begin
            c_in_valid = (cyc < 60);
            c_in_data  = 8'(cyc + 1);
            @(posedge clk);
            #1;
            if (c_out_valid) got.push_back(c_out_data);
            if (cyc >= 1 && cyc <= 60) chk("rt_valid", c_out_valid, 1);
        end
        c_in_valid = 1'b0;
        chk("rt_count", got.size(), 60);
        for (int j = 0; j < got.size(); j++)
            chk("rt_data", got[j], (j < 24) ? 0 : j - 23);

        // Gapped input: same symbol sequence, idle cycles hold out_data.
        pulse_reset();
        n = 0; last_a = 0; last_b = 0;
        for (int cyc = 0; cyc < 200 && n < 9; cyc++) begin
            v = (cyc < 6) ? 1'(pat[cyc]) : 1'($urandom_range(0, 1));
            step(v, 8'(n + 1), 1'b0);
            if (v) begin
                chk("gap_valid", a_valid, 1);
                chk("gap_a_data", a_data, ea_l[n]);
                chk("gap_b_data", b_data, eb_l[n]);
                last_a = ea_l[n];
                last_b = eb_l[n];
                n++;
            end else begin
                chk("gap_idle_valid", a_valid, 0);
                chk("gap_idle_hold", a_data, last_a);
                chk("gap_idle_hold_b", b_data, last_b);
            end
        end
        chk("gap_count", n, 9);

        // sync_clr mid-stream with a colliding valid symbol.
        pulse_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 1), 1'b0);
        step(1'b1, 8'd99, 1'b1);
        chk("clr_valid", a_valid, 0);
        chk("clr_data", a_data, 0);
        chk("clr_idx", a_idx, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(i + 1), 1'b0);
            chk("clr_after_a", a_data, ea_l[i]);
            chk("clr_after_b", b_data, eb_l[i]);
        end

        // Asynchronous reset between edges.
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i + 1), 1'b0);
        chk("arst_pre_data", a_data, 4);
        in_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("arst_valid", a_valid, 0);
        chk("arst_data", a_data, 0);
        chk("arst_idx", a_idx, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'(i + 1), 1'b0);
            chk("arst_replay_a", a_data, ea_l[i]);
            chk("arst_replay_b", b_data, eb_l[i]);
        end

        // Random valid/data/clear against the queue model.
        step(1'b0, 8'd0, 1'b1);
        model_clr();
        for (int cyc = 0; cyc < 400; cyc++) begin
            c = ($urandom_range(0, 31) == 0);
            v = ($urandom_range(0, 9) < 7);
            d = 8'($urandom);
            step(v, d, c);
            model_step(v, d, c);
            chk("rnd_valid", a_valid, m_valid);
            chk("rnd_a_data", a_data, m_da);
            chk("rnd_b_data", b_data, m_db);
            chk("rnd_idx", a_idx, m_idx);
            chk("rnd_b_idx", b_idx, m_idx);
            chk("rnd_b_valid", b_valid, m_valid);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
